// File: rtl/sad_search_scheduler_if.sv
// Position/result handshake bundle between the SAD search scheduler and the SAD pipeline front end.
interface sad_search_scheduler_if #(
    parameter int SAD_W = 32
);
    logic             PosReady;
    logic             PosValid;
    logic [31:0]      outx;
    logic [31:0]      outy;
    logic             ResValid;
    logic [SAD_W-1:0] ResSad;

    modport master (
        output PosValid, outx, outy,
        input  PosReady, ResValid, ResSad
    );

    modport slave (
        input  PosValid, outx, outy,
        output PosReady, ResValid, ResSad
    );
endinterface

// File: rtl/sad_search_scheduler.sv
// Raster-order SAD search scheduler with credit-limited issue and in-order minimum tracking.
// Optional feature macro: SAD_EARLY_EXIT_EN (a zero SAD result stops further issue).
module sad_search_scheduler #(
    parameter int FRAME_W      = 64,
    parameter int FRAME_H      = 64,
    parameter int WIN          = 4,
    parameter int MAX_INFLIGHT = 6,
    parameter int SAD_W        = 32
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    sad_search_scheduler_if.master pos,
    output logic                  Busy,
    output logic                  Done,
    output logic [31:0]           BestX,
    output logic [31:0]           BestY,
    output logic [SAD_W-1:0]      BestSad,
    output logic                  ErrUnexp
);
    localparam int          OW      = $clog2(MAX_INFLIGHT + 1);
    localparam logic [31:0] X_LAST  = 32'(FRAME_W - WIN);
    localparam logic [31:0] Y_LAST  = 32'(FRAME_H - WIN);
    localparam logic [OW-1:0] MAX_OUT = OW'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [31:0]     r_iss_x;
    logic [31:0]     r_iss_y;
    logic [31:0]     r_res_x;
    logic [31:0]     r_res_y;
    logic [OW-1:0]   r_outstanding;
    logic [OW-1:0]   w_out_next;
    logic            w_xfer;
    logic            w_res_ok;
    logic            w_last_iss;
    logic            w_stop;
    logic            w_start;

    assign pos.PosValid = (r_state == ST_ISSUE) && (r_outstanding < MAX_OUT);
    assign pos.outx     = r_iss_x;
    assign pos.outy     = r_iss_y;
    assign Busy         = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
    assign Done         = (r_state == ST_DONE);

    assign w_start    = (r_state == ST_IDLE) && Start;
    assign w_xfer     = pos.PosValid && pos.PosReady;
    // A result with nothing outstanding is stray and must not touch the search.
    assign w_res_ok   = pos.ResValid && (r_outstanding != '0);
    assign w_last_iss = (r_iss_x == X_LAST) && (r_iss_y == Y_LAST);

`ifdef SAD_EARLY_EXIT_EN
    assign w_stop = w_res_ok && (pos.ResSad == '0);
`else
    assign w_stop = 1'b0;
`endif

    // Outstanding credit count after this cycle's issue and return.
    always_comb begin
        w_out_next = r_outstanding;
        if (w_xfer && !w_res_ok) begin
            w_out_next = r_outstanding + OW'(1);
        end else if (!w_xfer && w_res_ok) begin
            w_out_next = r_outstanding - OW'(1);
        end else begin
            w_out_next = r_outstanding;
        end
    end

    // Next-state logic; DRAIN exits on the cycle the last result is accepted.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (Start) w_state_next = ST_ISSUE;
                else       w_state_next = ST_IDLE;
            end
            ST_ISSUE: begin
                if ((w_xfer && w_last_iss) || w_stop) w_state_next = ST_DRAIN;
                else                                  w_state_next = ST_ISSUE;
            end
            ST_DRAIN: begin
                if (w_out_next == '0) w_state_next = ST_DONE;
                else                  w_state_next = ST_DRAIN;
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State, credit counter and the issue/result raster counters.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state       <= ST_IDLE;
            r_outstanding <= '0;
            r_iss_x       <= 32'd0;
            r_iss_y       <= 32'd0;
            r_res_x       <= 32'd0;
            r_res_y       <= 32'd0;
        end else if (w_start) begin
            r_state       <= w_state_next;
            r_outstanding <= '0;
            r_iss_x       <= 32'd0;
            r_iss_y       <= 32'd0;
            r_res_x       <= 32'd0;
            r_res_y       <= 32'd0;
        end else begin
            r_state       <= w_state_next;
            r_outstanding <= w_out_next;
            if (w_xfer) begin
                if (r_iss_x == X_LAST) begin
                    r_iss_x <= 32'd0;
                    r_iss_y <= r_iss_y + 32'd1;
                end else begin
                    r_iss_x <= r_iss_x + 32'd1;
                end
            end
            if (w_res_ok) begin
                if (r_res_x == X_LAST) begin
                    r_res_x <= 32'd0;
                    r_res_y <= r_res_y + 32'd1;
                end else begin
                    r_res_x <= r_res_x + 32'd1;
                end
            end
        end
    end

    // Running minimum (strict less-than keeps the earliest tie) and the stray-result flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            BestX    <= 32'd0;
            BestY    <= 32'd0;
            BestSad  <= '0;
            ErrUnexp <= 1'b0;
        end else if (w_start) begin
            BestX    <= 32'd0;
            BestY    <= 32'd0;
            BestSad  <= '1;
            ErrUnexp <= 1'b0;
        end else begin
            if (w_res_ok && (pos.ResSad < BestSad)) begin
                BestX   <= r_res_x;
                BestY   <= r_res_y;
                BestSad <= pos.ResSad;
            end
            if (pos.ResValid && (r_outstanding == '0)) begin
                ErrUnexp <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sad_search_scheduler.sv
// Directed bench for sad_search_scheduler on an 8x8 frame with a 4x4 window (25 positions).
module tb_sad_search_scheduler;
    localparam int FW = 8;
    localparam int FH = 8;
    localparam int WN = 4;
    localparam int MI = 6;
    localparam int SW = 32;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Start;
    logic          Busy;
    logic          Done;
    logic [31:0]   BestX;
    logic [31:0]   BestY;
    logic [SW-1:0] BestSad;
    logic          ErrUnexp;

    int checks   = 0;
    int failures = 0;

    sad_search_scheduler_if #(.SAD_W(SW)) bus ();

    sad_search_scheduler #(
        .FRAME_W(FW), .FRAME_H(FH), .WIN(WN), .MAX_INFLIGHT(MI), .SAD_W(SW)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .pos(bus),
        .Busy(Busy), .Done(Done), .BestX(BestX), .BestY(BestY),
        .BestSad(BestSad), .ErrUnexp(ErrUnexp)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] sad_of(input int mode, input logic [31:0] x, input logic [31:0] y);
        case (mode)
            0:       return (x == 32'd3 && y == 32'd2) ? 32'd7 : 32'd100;
            1:       return ((x == 32'd1 && y == 32'd0) || (x == 32'd4 && y == 32'd4)) ? 32'd50 : 32'd90;
            2:       return (x == 32'd4 && y == 32'd0) ? 32'd0 : 32'd30;
            default: return 32'd100;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1; Start = 1'b0;
        bus.ResValid = 1'b0; bus.ResSad = 32'd0; bus.PosReady = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Pipeline model: every accepted position returns its SAD exactly 6 edges later, in order.
    task automatic run_search(input int mode, input bit ready_alt, input bit resp_en, input int ncyc,
                              input bit stop_on_done, output int xfers, output int dones,
                              output int coord_err, output int max_out, output logic first_valid,
                              output logic busy_after);
        logic [31:0] qx[$];
        logic [31:0] qy[$];
        int          qdue[$];
        logic [31:0] ex, ey, hx, hy;
        bit          hold_chk;
        int          outst, post;
        xfers = 0; dones = 0; coord_err = 0; max_out = 0; outst = 0; post = -1;
        ex = 32'd0; ey = 32'd0; hx = 32'd0; hy = 32'd0; hold_chk = 1'b0;
        first_valid = 1'b0; busy_after = 1'bx;
        @(negedge Clk);
        Start = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge Clk);
            Start = 1'b0;
            if (c == 0) first_valid = bus.PosValid;
            if (hold_chk && (bus.outx !== hx || bus.outy !== hy)) coord_err++;
            hold_chk = 1'b0;
            bus.PosReady = ready_alt ? ((c % 2) == 1) : 1'b1;
            if (bus.PosValid === 1'b1) begin
                if (bus.outx !== ex || bus.outy !== ey) coord_err++;
                if (bus.PosReady) begin
                    xfers++; outst++;
                    qx.push_back(ex); qy.push_back(ey); qdue.push_back(c + 6);
                    if (ex == 32'(FW - WN)) begin ex = 32'd0; ey = ey + 32'd1; end
                    else ex = ex + 32'd1;
                end else begin
                    hold_chk = 1'b1; hx = bus.outx; hy = bus.outy;
                end
            end
            bus.ResValid = 1'b0;
            if (resp_en && qdue.size() > 0 && qdue[0] == c) begin
                bus.ResValid = 1'b1;
                bus.ResSad   = sad_of(mode, qx[0], qy[0]);
                void'(qx.pop_front()); void'(qy.pop_front()); void'(qdue.pop_front());
                outst--;
            end
            if (outst > max_out) max_out = outst;
            if (Done === 1'b1) begin
                dones++;
                if (stop_on_done && post < 0) post = c;
            end
            if (post >= 0 && c == post + 1) busy_after = Busy;
            if (post >= 0 && c == post + 3) break;
        end
        bus.ResValid = 1'b0;
        bus.PosReady = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.PosValid !== 1'b0) begin failures++; $display("FAIL reset_posvalid got=%b exp=0", bus.PosValid); end
        checks++; if (Busy !== 1'b0)         begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        checks++; if (Done !== 1'b0)         begin failures++; $display("FAIL reset_done got=%b exp=0", Done); end
        checks++; if (BestSad !== 32'd0)     begin failures++; $display("FAIL reset_bestsad got=%0d exp=0", BestSad); end
        checks++; if (BestX !== 32'd0 || BestY !== 32'd0) begin failures++; $display("FAIL reset_bestxy got=%0d,%0d exp=0,0", BestX, BestY); end
        checks++; if (ErrUnexp !== 1'b0)     begin failures++; $display("FAIL reset_err got=%b exp=0", ErrUnexp); end
        checks++; if (bus.outx !== 32'd0 || bus.outy !== 32'd0) begin failures++; $display("FAIL reset_coords got=%0d,%0d exp=0,0", bus.outx, bus.outy); end
    endtask

    task automatic test_basic_search();
        int x, d, ce, mo; logic fv, ba;
        run_search(0, 1'b0, 1'b1, 300, 1'b1, x, d, ce, mo, fv, ba);
        checks++; if (fv !== 1'b1)   begin failures++; $display("FAIL t1_latency posvalid got=%b exp=1", fv); end
        checks++; if (x != 25)       begin failures++; $display("FAIL t1_transfers got=%0d exp=25", x); end
        checks++; if (d != 1)        begin failures++; $display("FAIL t1_done_pulses got=%0d exp=1", d); end
        checks++; if (ce != 0)       begin failures++; $display("FAIL t1_coord_order errors got=%0d exp=0", ce); end
        checks++; if (mo > MI)       begin failures++; $display("FAIL t1_credit max_outstanding got=%0d exp<=%0d", mo, MI); end
        checks++; if (BestX !== 32'd3 || BestY !== 32'd2) begin failures++; $display("FAIL t1_bestxy got=%0d,%0d exp=3,2", BestX, BestY); end
        checks++; if (BestSad !== 32'd7) begin failures++; $display("FAIL t1_bestsad got=%0d exp=7", BestSad); end
        checks++; if (ba !== 1'b0)   begin failures++; $display("FAIL t1_busy_after_done got=%b exp=0", ba); end
        checks++; if (ErrUnexp !== 1'b0) begin failures++; $display("FAIL t1_err got=%b exp=0", ErrUnexp); end
    endtask

    task automatic test_tie();
        int x, d, ce, mo; logic fv, ba;
        run_search(1, 1'b0, 1'b1, 300, 1'b1, x, d, ce, mo, fv, ba);
        checks++; if (BestX !== 32'd1 || BestY !== 32'd0) begin failures++; $display("FAIL t3_tie_bestxy got=%0d,%0d exp=1,0", BestX, BestY); end
        checks++; if (BestSad !== 32'd50) begin failures++; $display("FAIL t3_tie_bestsad got=%0d exp=50", BestSad); end
        checks++; if (d != 1)        begin failures++; $display("FAIL t3_done_pulses got=%0d exp=1", d); end
    endtask

    task automatic test_backpressure();
        int x, d, ce, mo; logic fv, ba;
        run_search(0, 1'b1, 1'b1, 400, 1'b1, x, d, ce, mo, fv, ba);
        checks++; if (x != 25)       begin failures++; $display("FAIL bp_transfers got=%0d exp=25", x); end
        checks++; if (ce != 0)       begin failures++; $display("FAIL bp_coord_hold errors got=%0d exp=0", ce); end
        checks++; if (BestX !== 32'd3 || BestY !== 32'd2 || BestSad !== 32'd7) begin failures++; $display("FAIL bp_best got=%0d,%0d,%0d exp=3,2,7", BestX, BestY, BestSad); end
    endtask

    task automatic test_credit_stall();
        int x, d, ce, mo; logic fv, ba;
        run_search(0, 1'b0, 1'b0, 20, 1'b0, x, d, ce, mo, fv, ba);
        checks++; if (x != MI)       begin failures++; $display("FAIL t2_transfers got=%0d exp=%0d", x, MI); end
        checks++; if (bus.PosValid !== 1'b0) begin failures++; $display("FAIL t2_posvalid_stalled got=%b exp=0", bus.PosValid); end
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL t2_busy got=%b exp=1", Busy); end
        do_reset();
    endtask

    task automatic test_reset_mid();
        int x, d, ce, mo, nd; logic fv, ba;
        run_search(0, 1'b0, 1'b1, 10, 1'b0, x, d, ce, mo, fv, ba);
        Reset = 1'b1;
        @(negedge Clk);
        checks++; if (bus.PosValid !== 1'b0) begin failures++; $display("FAIL t4_posvalid got=%b exp=0", bus.PosValid); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL t4_busy got=%b exp=0", Busy); end
        checks++; if (BestSad !== 32'd0) begin failures++; $display("FAIL t4_bestsad got=%0d exp=0", BestSad); end
        Reset = 1'b0;
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            if (Done === 1'b1) nd++;
        end
        checks++; if (nd != 0) begin failures++; $display("FAIL t4_done_after_reset got=%0d exp=0", nd); end
    endtask

    task automatic test_unexpected();
        do_reset();
        @(negedge Clk); bus.ResValid = 1'b1; bus.ResSad = 32'd5;
        @(negedge Clk); bus.ResValid = 1'b0;
        checks++; if (ErrUnexp !== 1'b1) begin failures++; $display("FAIL t5_err_set got=%b exp=1", ErrUnexp); end
        checks++; if (BestSad !== 32'd0) begin failures++; $display("FAIL t5_stray_discarded bestsad got=%0d exp=0", BestSad); end
        repeat (5) @(negedge Clk);
        checks++; if (ErrUnexp !== 1'b1) begin failures++; $display("FAIL t5_err_sticky got=%b exp=1", ErrUnexp); end
        Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        checks++; if (ErrUnexp !== 1'b0) begin failures++; $display("FAIL t5_err_cleared_by_start got=%b exp=0", ErrUnexp); end
        do_reset();
    endtask

    task automatic test_zero_sad();
        int x, d, ce, mo; logic fv, ba;
        run_search(2, 1'b0, 1'b1, 300, 1'b1, x, d, ce, mo, fv, ba);
`ifdef SAD_EARLY_EXIT_EN
        checks++; if (x >= 25) begin failures++; $display("FAIL t6_early_exit transfers got=%0d exp<25", x); end
`else
        checks++; if (x != 25) begin failures++; $display("FAIL t6_full_issue transfers got=%0d exp=25", x); end
`endif
        checks++; if (BestSad !== 32'd0) begin failures++; $display("FAIL t6_bestsad got=%0d exp=0", BestSad); end
        checks++; if (BestX !== 32'd4 || BestY !== 32'd0) begin failures++; $display("FAIL t6_bestxy got=%0d,%0d exp=4,0", BestX, BestY); end
        checks++; if (d != 1) begin failures++; $display("FAIL t6_done_pulses got=%0d exp=1", d); end
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0;
        bus.PosReady = 1'b1; bus.ResValid = 1'b0; bus.ResSad = 32'd0;
        test_reset();
        test_basic_search();
        test_tie();
        test_backpressure();
        test_credit_stall();
        test_reset_mid();
        test_unexpected();
        test_zero_sad();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
